// File: rtl/daq_packetizer.sv
// rtl/daq_packetizer.sv - ADC sample FIFO and fixed-length AXI-Stream packet framer
// Buffers {ch, sample} words and emits header + PKT_LEN payload beats per packet.
module daq_packetizer #(
  parameter int DATA_W     = 32,
  parameter int USER_W     = 8,
  parameter int SAMPLE_W   = 16,
  parameter int PKT_LEN    = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  input  logic [3:0]          smp_ch,
  output logic [DATA_W-1:0]   m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [USER_W-1:0]   m_tuser,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         pkt_cnt,
  output logic                busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = SAMPLE_W + 4;
  localparam logic [15:0] LEN16     = 16'(PKT_LEN);
  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t        state;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [7:0]    seq;
  logic [15:0]   beat_cnt;
  logic          ovf_flag;

  logic          full, empty, push, drop, hs, hdr_hs, pop, last_beat;
  logic [EW-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head      = mem[rptr[AW-1:0]];
  assign push      = smp_valid && !full;
  assign drop      = smp_valid && full;
  assign last_beat = (beat_cnt == LAST_BEAT);

  assign m_tvalid  = (state == HEADER) || ((state == PAYLOAD) && !empty);
  assign hs        = m_tvalid && m_tready;
  assign hdr_hs    = hs && (state == HEADER);
  assign pop       = hs && (state == PAYLOAD);
  assign busy      = (state != IDLE);

  always_comb begin
    m_tdata = '0;
    m_tuser = '0;
    m_tlast = 1'b0;
    case (state)
      HEADER: begin
        m_tdata = DATA_W'({8'hA5, seq, LEN16});
        m_tuser = USER_W'({ovf_flag, 6'b000000, 1'b1});
      end
      PAYLOAD: begin
        m_tdata = DATA_W'(head);
        m_tlast = last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {smp_ch, smp_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      state    <= IDLE;
      seq      <= '0;
      beat_cnt <= '0;
      ovf_flag <= 1'b0;
      drop_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      // A drop in the header handshake cycle keeps the flag for the next header.
      if (drop)        ovf_flag <= 1'b1;
      else if (hdr_hs) ovf_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && !empty) state <= HEADER;
        end
        HEADER: begin
          if (hdr_hs) begin
            state    <= PAYLOAD;
            seq      <= seq + 8'd1;
            beat_cnt <= '0;
          end
        end
        PAYLOAD: begin
          if (pop) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (last_beat) begin
              state   <= IDLE;
              pkt_cnt <= pkt_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_daq_packetizer.sv
// tb/tb_daq_packetizer.sv - self-checking bench for daq_packetizer with a stream-level model
module tb_daq_packetizer;

  localparam int LEN   = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = '0;
  logic [3:0]  smp_ch = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [7:0]  m_tuser;
  logic [15:0] drop_cnt, pkt_cnt;
  logic        busy;

  daq_packetizer #(.DATA_W(32), .USER_W(8), .SAMPLE_W(16), .PKT_LEN(LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .smp_valid(smp_valid), .smp_data(smp_data),
    .smp_ch(smp_ch), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Beats are packed as {tlast, tuser, tdata}.
  logic [40:0] obs[$];
  logic [40:0] expq[$];
  logic [19:0] mq[$];
  int          m_pos, m_drop, m_pkt;
  logic [7:0]  m_seq;
  logic        m_ovf;

  // Reference: a bounded sample queue feeding a header + LEN-sample packet stream.
  always @(negedge clk) begin : model
    int pos, drop_n, pkt;
    logic [7:0] sq;
    logic ovf, full_now;
    logic [40:0] e;
    if (rst) begin
      mq.delete();
      m_pos <= 0; m_seq <= 8'h00; m_ovf <= 1'b0; m_drop <= 0; m_pkt <= 0;
    end else begin
      pos = m_pos; sq = m_seq; ovf = m_ovf; drop_n = m_drop; pkt = m_pkt;
      full_now = (mq.size() == DEPTH);
      if (m_tvalid && m_tready) begin
        obs.push_back({m_tlast, m_tuser, m_tdata});
        if (pos == 0) begin
          expq.push_back({1'b0, (ovf ? 8'h81 : 8'h01), 8'hA5, sq, 16'(LEN)});
          sq = sq + 8'd1; ovf = 1'b0; pos = 1;
        end else begin
          if (mq.size() == 0) e = 'x;
          else e = {(pos == LEN), 8'h00, 12'h000, mq.pop_front()};
          expq.push_back(e);
          if (pos == LEN) begin pos = 0; pkt++; end
          else pos++;
        end
      end
      if (smp_valid) begin
        if (full_now) begin
          ovf = 1'b1;
          if (drop_n < 65535) drop_n++;
        end else mq.push_back({smp_ch, smp_data});
      end
      m_pos <= pos; m_seq <= sq; m_ovf <= ovf; m_drop <= drop_n; m_pkt <= pkt;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [3:0] ch, input logic [15:0] d);
    step(); smp_valid = 1'b1; smp_ch = ch; smp_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); smp_valid = 1'b0; end
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int i = 0; i < budget && obs.size() < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    step(); rst = 1'b1; smp_valid = 1'b0;
    step(); rst = 1'b0;
    obs.delete(); expq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (m_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
    n_cmp++; if (m_tdata !== 32'h0) begin n_bad++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
    n_cmp++; if (m_tuser !== 8'h0) begin n_bad++; $display("FAIL rst_tuser got %h want 0", m_tuser); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_drop got %h want 0", drop_cnt); end
    n_cmp++; if (pkt_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_pkt got %h want 0", pkt_cnt); end
  endtask

  task automatic test_basic();
    enable = 1'b1; m_tready = 1'b1;
    push(4'd3, 16'h0001);
    push(4'd3, 16'h0002);
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL lat_n1 tvalid got %b want 0", m_tvalid); end
    push(4'd3, 16'h0003);
    @(negedge clk);
    n_cmp++; if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, 32'hA5000004, 8'h01}) begin
      n_bad++; $display("FAIL lat_n2 hdr got %b %h %h want 1 a5000004 01", m_tvalid, m_tdata, m_tuser); end
    push(4'd3, 16'h0004);
    idle(1);
    wait_beats(5, 50);
    n_cmp++; if (obs.size() !== 5) begin n_bad++; $display("FAIL basic_count got %0d want 5", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL basic_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    n_cmp++; if (obs[1] !== {1'b0, 8'h00, 32'h00030001}) begin n_bad++; $display("FAIL basic_p1 got %h want 0000030001", obs[1]); end
    n_cmp++; if (obs[4] !== {1'b1, 8'h00, 32'h00030004}) begin n_bad++; $display("FAIL basic_p4 got %h want 10000030004", obs[4]); end
    idle(2); @(negedge clk);
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL basic_pkt got %0d want 1", pkt_cnt); end
    obs.delete(); expq.delete();
  endtask

  task automatic test_backpressure();
    logic [41:0] prev;
    logic        prev_stall;
    prev_stall = 1'b0; prev = '0;
    for (int k = 0; k < 40; k++) begin
      step();
      m_tready  = (k % 4 == 0) || (k % 4 == 3);
      smp_valid = (k < 4);
      smp_ch    = 4'($urandom_range(0, 15));
      smp_data  = 16'($urandom);
      @(negedge clk);
      if (prev_stall) begin
        n_cmp++; if ({m_tvalid, m_tlast, m_tuser, m_tdata} !== prev) begin
          n_bad++; $display("FAIL bp_stable k%0d got %h want %h", k, {m_tvalid, m_tlast, m_tuser, m_tdata}, prev); end
      end
      prev       = {m_tvalid, m_tlast, m_tuser, m_tdata};
      prev_stall = m_tvalid && !m_tready;
    end
    n_cmp++; if (obs.size() !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL bp_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    n_cmp++; if (obs[0][31:0] !== 32'hA5010004) begin n_bad++; $display("FAIL bp_hdr got %h want a5010004", obs[0][31:0]); end
    n_cmp++; if (pkt_cnt !== 16'd2) begin n_bad++; $display("FAIL bp_pkt got %0d want 2", pkt_cnt); end
    obs.delete(); expq.delete();
  endtask

  task automatic test_overflow();
    enable = 1'b0; m_tready = 1'b0;
    for (int i = 0; i < 10; i++) push(4'($urandom_range(0, 15)), 16'($urandom));
    idle(2); @(negedge clk);
    n_cmp++; if (drop_cnt !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_busy got %b want 0", busy); end
    step(); enable = 1'b1; m_tready = 1'b1;
    wait_beats(10, 100);
    n_cmp++; if (obs.size() !== 10) begin n_bad++; $display("FAIL ovf_count got %0d want 10", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL ovf_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    n_cmp++; if (obs[0][39:32] !== 8'h81) begin n_bad++; $display("FAIL ovf_hdr1 tuser got %h want 81", obs[0][39:32]); end
    n_cmp++; if (obs[5][39:32] !== 8'h01) begin n_bad++; $display("FAIL ovf_hdr2 tuser got %h want 01", obs[5][39:32]); end
    idle(3);
    obs.delete(); expq.delete();
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 16'($urandom));
    idle(1);
    wait_beats(3, 50);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_tvalid got %b want 0", m_tvalid); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rmid_drop got %0d want 0", drop_cnt); end
    idle(3); @(negedge clk);
    n_cmp++; if ({busy, m_tvalid} !== 2'b00) begin n_bad++; $display("FAIL rmid_empty got %b want 00", {busy, m_tvalid}); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL rmid_pre%0d got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    for (int i = 0; i < 4; i++) push(4'($urandom_range(0, 15)), 16'($urandom));
    idle(1);
    wait_beats(5, 50);
    n_cmp++; if (obs.size() !== 5) begin n_bad++; $display("FAIL rmid_count got %0d want 5", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL rmid_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    n_cmp++; if (obs[0][31:0] !== 32'hA5000004) begin n_bad++; $display("FAIL rmid_hdr got %h want a5000004", obs[0][31:0]); end
    idle(3);
    obs.delete(); expq.delete();
  endtask

  task automatic test_enable_drop();
    do_reset();
    enable = 1'b1; m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push(4'($urandom_range(0, 15)), 16'($urandom));
    idle(2);
    m_tready = 1'b1;
    wait_beats(3, 50);
    enable = 1'b0;
    wait_beats(5, 50);
    idle(10); @(negedge clk);
    n_cmp++; if (obs.size() !== 5) begin n_bad++; $display("FAIL en_count got %0d want 5", obs.size()); end
    n_cmp++; if (obs[4][40] !== 1'b1) begin n_bad++; $display("FAIL en_tlast got %b want 1", obs[4][40]); end
    n_cmp++; if ({busy, m_tvalid} !== 2'b00) begin n_bad++; $display("FAIL en_idle got %b want 00", {busy, m_tvalid}); end
    step(); enable = 1'b1;
    for (int i = 0; i < 2; i++) push(4'($urandom_range(0, 15)), 16'($urandom));
    idle(1);
    wait_beats(10, 60);
    n_cmp++; if (obs.size() !== 10) begin n_bad++; $display("FAIL en_count2 got %0d want 10", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL en_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    n_cmp++; if (obs[5][31:0] !== 32'hA5010004) begin n_bad++; $display("FAIL en_hdr got %h want a5010004", obs[5][31:0]); end
    idle(3); @(negedge clk);
    n_cmp++; if (pkt_cnt !== 16'd2) begin n_bad++; $display("FAIL en_pkt got %0d want 2", pkt_cnt); end
    obs.delete(); expq.delete();
  endtask

  task automatic test_seq_wrap();
    int cyc;
    do_reset();
    enable = 1'b1;
    cyc = 0;
    while (m_pkt < 257 && cyc < 20000) begin
      step();
      smp_valid = 1'($urandom_range(0, 1));
      smp_ch    = 4'($urandom_range(0, 15));
      smp_data  = 16'($urandom);
      m_tready  = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    enable = 1'b0; smp_valid = 1'b0; m_tready = 1'b1;
    idle(6); @(negedge clk);
    n_cmp++; if (pkt_cnt !== 16'd257) begin n_bad++; $display("FAIL wrap_pkt got %0d want 257", pkt_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wrap_busy got %b want 0", busy); end
    n_cmp++; if (obs.size() !== 257 * 5) begin n_bad++; $display("FAIL wrap_count got %0d want %0d", obs.size(), 257 * 5); end
    if (obs.size() >= 257 * 5) begin
      n_cmp++; if (obs[255 * 5][23:16] !== 8'hFF) begin n_bad++; $display("FAIL wrap_seqff got %h want ff", obs[255 * 5][23:16]); end
      n_cmp++; if (obs[256 * 5][23:16] !== 8'h00) begin n_bad++; $display("FAIL wrap_seq00 got %h want 00", obs[256 * 5][23:16]); end
    end
    for (int i = 0; i < obs.size(); i++) begin
      n_cmp++; if (obs[i] !== expq[i]) begin n_bad++; $display("FAIL wrap_beat%0d got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
  endtask

  task automatic test_drop_sat();
    do_reset();
    enable = 1'b0; m_tready = 1'b0;
    step(); smp_valid = 1'b1; smp_data = 16'($urandom); smp_ch = 4'd5;
    repeat (1008) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (drop_cnt !== 16'd1000) begin n_bad++; $display("FAIL sat_mid got %0d want 1000", drop_cnt); end
    repeat (69100) @(posedge clk);
    #1; smp_valid = 1'b0;
    idle(1); @(negedge clk);
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_drop got %h want ffff", drop_cnt); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_enable_drop();
    test_seq_wrap();
    test_drop_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/daq_packetizer.md
Name: daq_packetizer

Overview:
- Upstream framing stage of the DAQ streaming pipeline. Accepts raw per-channel ADC samples and buffers them in a small FIFO.
- Emits fixed-length AXI-Stream packets: one header beat, then PKT_LEN payload beats, with tlast on the final beat.
- Its m_* outputs connect directly to the master side of an axi_if instance, which feeds the downstream pipeline.
- Drops samples on overflow, counts them, and flags the overflow in the next header.

Parameters:
- DATA_W, 32, AXI-Stream tdata width; must be ≥ SAMPLE_W+4 and ≥ 32.
- USER_W, 8, AXI-Stream tuser width; must be ≥ 8.
- SAMPLE_W, 16, ADC sample width.
- PKT_LEN, 64, payload beats per packet; range 1..65535.
- FIFO_DEPTH, 16, sample FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  permits new packets to start
- smp_valid  in  1  sample strobe, one sample per cycle, no backpressure
- smp_data  in  SAMPLE_W  sample value
- smp_ch  in  4  channel id
- m_tdata  out  DATA_W  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  end of packet
- m_tuser  out  USER_W  sideband
- drop_cnt  out  16  samples dropped, saturating
- pkt_cnt  out  16  packets completed, wrapping
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (clk edge with rst=1) clears:
  - FIFO pointers, so the FIFO is empty;
  - FSM state to IDLE, seq=0, beat_cnt=0, ovf_flag=0;
  - drop_cnt and pkt_cnt to 0.
- Reset values of outputs: m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, busy=0.
- Reset mid-packet abandons the partial packet; no tlast is emitted.
- FIFO write:
  - Entry is {smp_ch, smp_data}.
  - Written when smp_valid=1 and the registered full flag is 0.
  - If smp_valid=1 and full=1, the sample is dropped, drop_cnt increments (holds at 0xFFFF), and ovf_flag is set. This applies even if a pop happens in the same cycle.
  - The FIFO is first-word-fall-through: a sample written in cycle N is visible at the head in cycle N+1.
  - Pointer wrap is modulo FIFO_DEPTH; full/empty is resolved with an extra pointer MSB.
- FSM:
  - IDLE: m_tvalid=0. If enable=1 and the FIFO is not empty, go to HEADER on the next cycle.
  - HEADER: m_tvalid=1 and m_tlast=0.
    - m_tdata = {0x A5, seq[7:0], PKT_LEN[15:0]}, zero-extended to DATA_W.
    - m_tuser[0]=1 (header marker), m_tuser[7]=ovf_flag, all other bits 0.
    - On handshake (tvalid & tready): go to PAYLOAD, seq increments (wraps at 255), beat_cnt=0.
    - On the same handshake ovf_flag clears, unless a drop happens in that cycle, in which case it stays 1.
  - PAYLOAD: m_tvalid = !fifo_empty.
    - m_tdata = {zeros, ch, data} with data in [SAMPLE_W-1:0] and ch in [SAMPLE_W+3:SAMPLE_W].
    - m_tuser = 0.
    - m_tlast = (beat_cnt == PKT_LEN-1).
    - Each handshake pops the FIFO and increments beat_cnt.
    - The handshake on the tlast beat returns the FSM to IDLE and increments pkt_cnt.
- AXI rules:
  - Once asserted, m_tvalid, m_tdata, m_tlast and m_tuser stay stable until the handshake. Only a pop can empty the FIFO, which guarantees this.
  - m_tvalid does not depend on m_tready combinationally.
- enable deasserted mid-packet: the current packet completes in full; the FSM stays in IDLE afterwards.
- Throughput: with tready held high and the FIFO kept fed, payload runs at 1 beat/cycle. Each packet costs one IDLE cycle plus one HEADER cycle.
- Latency: first sample at cycle N → HEADER valid at N+2 (FIFO visible N+1, IDLE→HEADER), first payload beat at N+3.

Test Plan (bench parameters: PKT_LEN=4, FIFO_DEPTH=8, SAMPLE_W=16, DATA_W=32):
- Reset, enable=1, push samples 0x0001..0x0004 on ch 3, tready=1 → header 0xA5000004 with tuser=0x01; payload 0x00030001..0x00030004; tlast only on beat 4; pkt_cnt=1, seq=1.
- Same stimulus with tready toggling 1,0,0,1 → no beat lost or duplicated, and all m_* outputs hold stable while tready=0.
- tready=0, push 10 samples → first 8 stored, drop_cnt=2; next header has tuser=0x81; the header after that has tuser=0x01.
- Assert rst after payload beat 2 → next cycle m_tvalid=0, FIFO empty, seq=0, drop_cnt=0; the next packet header is 0xA5000004.
- Deassert enable during payload beat 2 with 6 samples queued → the packet finishes with beats 3 and 4 and tlast; the FSM stays in IDLE with 2 samples still queued; re-enable → new header with seq=1.
- Drive 257 packets → the seq byte in the header wraps 0xFF→0x00; pkt_cnt=257; force 70000 drops → drop_cnt saturates at 0xFFFF.
